decode_stage: RTL and testbench

Registered RV32I decode stage with valid/ready handshake on both sides, an optional skid buffer, flush, and load-use hazard hold. It sits between the fetch stage and execute, and generalises the combinational field slicer, control decoder and immediate generator into a pipelined stage. Parameters set datapath width, skid buffering and illegal-opcode trapping.

---
 rtl/decode_stage.sv | 217 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: field slicer, control decoder and immediate generator behind a valid/ready register.
// Latency: one cycle from accept to out_*; out_valid additionally gated by the load-use hazard.
// Backpressure: SKID=1 gives registered in_ready via a one-entry skid; SKID=0 gives combinational in_ready.
module decode_stage #(
    parameter int XLEN         = 32,
    parameter int SKID         = 1,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            ex_load_valid,
    input  logic [4:0]      ex_load_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic [XLEN-1:0] out_imm,
    output logic            out_regWrite,
    output logic            out_MemRead,
    output logic            out_MemWrite,
    output logic            out_ALUSrc,
    output logic            out_Branch,
    output logic            out_Jump,
    output logic            out_JAL,
    output logic            out_JALR,
    output logic [1:0]      out_ALUOp,
    output logic [2:0]      out_ImmSrc,
    output logic [1:0]      out_wb_sel,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [XLEN-1:0] imm;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            alusrc;
        logic            branch;
        logic            jump;
        logic            jal;
        logic            jalr;
        logic [1:0]      aluop;
        logic [2:0]      immsrc;
        logic [1:0]      wb_sel;
        logic            rs1_used;
        logic            rs2_used;
        logic            illegal;
    } dec_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    dec_t        dec;
    dec_t        main_q;
    dec_t        skid_q;
    logic        reg_valid;
    logic        skid_valid;
    logic [31:0] imm32;
    logic        haz;
    logic        drain;
    logic        accept;

    // Every legal opcode ends in 2'b11, so malformed low bits fall into the default arm.
    always_comb begin
        dec          = '0;
        imm32        = '0;
        dec.pc       = in_pc;
        dec.rd       = in_instr[11:7];
        dec.rs1      = in_instr[19:15];
        dec.rs2      = in_instr[24:20];
        dec.funct3   = in_instr[14:12];
        dec.funct7b5 = in_instr[30];
        case (in_instr[6:0])
            OP_R: begin
                dec.regwrite = 1'b1; dec.aluop = 2'b10; dec.immsrc = 3'd7;
                dec.rs1_used = 1'b1; dec.rs2_used = 1'b1;
            end
            OP_IALU: begin
                dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 2'b10; dec.immsrc = 3'd0;
                dec.rs1_used = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_LOAD: begin
                dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.memread = 1'b1; dec.wb_sel = 2'd1;
                dec.immsrc = 3'd0; dec.rs1_used = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_STORE: begin
                dec.alusrc = 1'b1; dec.memwrite = 1'b1; dec.immsrc = 3'd1;
                dec.rs1_used = 1'b1; dec.rs2_used = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BRANCH: begin
                dec.branch = 1'b1; dec.aluop = 2'b01; dec.immsrc = 3'd2;
                dec.rs1_used = 1'b1; dec.rs2_used = 1'b1;
                imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                         in_instr[11:8], 1'b0};
            end
            OP_JAL: begin
                dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.jump = 1'b1; dec.jal = 1'b1;
                dec.wb_sel = 2'd2; dec.immsrc = 3'd4;
                imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.jump = 1'b1; dec.jalr = 1'b1;
                dec.wb_sel = 2'd2; dec.immsrc = 3'd0; dec.rs1_used = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_LUI: begin
                dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 2'b11; dec.immsrc = 3'd3;
                imm32 = {in_instr[31:12], 12'b0};
            end
            OP_AUIPC: begin
                dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.immsrc = 3'd3;
                imm32 = {in_instr[31:12], 12'b0};
            end
            default: dec.illegal = (ILLEGAL_TRAP != 0);
        endcase
        dec.imm = XLEN'($signed(imm32));
    end

    assign haz = reg_valid && ex_load_valid && (ex_load_rd != 5'd0) &&
                 ((main_q.rs1_used && (main_q.rs1 == ex_load_rd)) ||
                  (main_q.rs2_used && (main_q.rs2 == ex_load_rd)));

    assign out_valid = reg_valid && !haz;
    assign drain     = out_valid && out_ready;
    assign in_ready  = (SKID != 0) ? !skid_valid : (!reg_valid || drain);
    assign accept    = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_valid  <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            reg_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (SKID != 0) begin
            // A full skid forces in_ready low, so drain-with-skid never coincides with accept.
            if (drain) begin
                if (skid_valid) begin
                    main_q     <= skid_q;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_q <= dec;
                end else begin
                    reg_valid <= 1'b0;
                end
            end else if (accept) begin
                if (reg_valid) begin
                    skid_q     <= dec;
                    skid_valid <= 1'b1;
                end else begin
                    main_q    <= dec;
                    reg_valid <= 1'b1;
                end
            end
        end else begin
            if (accept) begin
                main_q    <= dec;
                reg_valid <= 1'b1;
            end else if (drain) begin
                reg_valid <= 1'b0;
            end
        end
    end

    assign out_pc       = main_q.pc;
    assign out_rd       = main_q.rd;
    assign out_rs1      = main_q.rs1;
    assign out_rs2      = main_q.rs2;
    assign out_funct3   = main_q.funct3;
    assign out_funct7b5 = main_q.funct7b5;
    assign out_imm      = main_q.imm;
    assign out_regWrite = main_q.regwrite;
    assign out_MemRead  = main_q.memread;
    assign out_MemWrite = main_q.memwrite;
    assign out_ALUSrc   = main_q.alusrc;
    assign out_Branch   = main_q.branch;
    assign out_Jump     = main_q.jump;
    assign out_JAL      = main_q.jal;
    assign out_JALR     = main_q.jalr;
    assign out_ALUOp    = main_q.aluop;
    assign out_ImmSrc   = main_q.immsrc;
    assign out_wb_sel   = main_q.wb_sel;
    assign out_rs1_used = main_q.rs1_used;
    assign out_rs2_used = main_q.rs2_used;
    assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two XLEN=64 instances (SKID=1/TRAP=1 and SKID=0/TRAP=0) driven identically,
// checked every cycle against a queue-level model plus directed literal expectations.
module tb_decode_stage;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        f7b5;
        logic [63:0] imm;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        alusrc;
        logic        branch;
        logic        jump;
        logic        jal;
        logic        jalr;
        logic [1:0]  aluop;
        logic [2:0]  immsrc;
        logic [1:0]  wb_sel;
        logic        rs1_used;
        logic        rs2_used;
        logic        illegal;
    } dec_t;

    localparam logic [31:0] I_ADDI = 32'h07F08313;
    localparam logic [31:0] I_LW   = 32'h0181A383;
    localparam logic [31:0] I_BEQ  = 32'h00208863;
    localparam logic [31:0] I_JAL  = 32'h020000EF;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_SW   = 32'hFE20AE23;
    localparam logic [31:0] I_ADD  = 32'h002082B3;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        flush;
    logic        ex_load_valid;
    logic [4:0]  ex_load_rd;
    logic        out_ready;

    logic        in_ready_w [2];
    logic        out_valid_w [2];
    logic [63:0] o_pc [2];
    logic [4:0]  o_rd [2];
    logic [4:0]  o_rs1 [2];
    logic [4:0]  o_rs2 [2];
    logic [2:0]  o_f3 [2];
    logic        o_f7 [2];
    logic [63:0] o_imm [2];
    logic        o_rw [2], o_mr [2], o_mw [2], o_as [2], o_br [2], o_jp [2], o_jal [2], o_jalr [2];
    logic [1:0]  o_aluop [2];
    logic [2:0]  o_immsrc [2];
    logic [1:0]  o_wb [2];
    logic        o_u1 [2], o_u2 [2], o_ill [2];
    dec_t        act [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        decode_stage #(
            .XLEN(64), .SKID(g == 0 ? 1 : 0), .ILLEGAL_TRAP(g == 0 ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[g]),
            .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
            .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
            .out_valid(out_valid_w[g]), .out_ready(out_ready), .out_pc(o_pc[g]),
            .out_rd(o_rd[g]), .out_rs1(o_rs1[g]), .out_rs2(o_rs2[g]),
            .out_funct3(o_f3[g]), .out_funct7b5(o_f7[g]), .out_imm(o_imm[g]),
            .out_regWrite(o_rw[g]), .out_MemRead(o_mr[g]), .out_MemWrite(o_mw[g]),
            .out_ALUSrc(o_as[g]), .out_Branch(o_br[g]), .out_Jump(o_jp[g]),
            .out_JAL(o_jal[g]), .out_JALR(o_jalr[g]), .out_ALUOp(o_aluop[g]),
            .out_ImmSrc(o_immsrc[g]), .out_wb_sel(o_wb[g]),
            .out_rs1_used(o_u1[g]), .out_rs2_used(o_u2[g]), .out_illegal(o_ill[g])
        );
        assign act[g] = {o_pc[g], o_rd[g], o_rs1[g], o_rs2[g], o_f3[g], o_f7[g], o_imm[g],
                         o_rw[g], o_mr[g], o_mw[g], o_as[g], o_br[g], o_jp[g], o_jal[g], o_jalr[g],
                         o_aluop[g], o_immsrc[g], o_wb[g], o_u1[g], o_u2[g], o_ill[g]};
    end

    int   checks = 0;
    int   fails = 0;
    bit   started = 0;
    dec_t ment [2][2];
    int   mcnt [2];
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    task automatic chk_v(input string name, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic got, input logic exp);
        chk_v(name, 192'(got), 192'(exp));
    endtask

    // Reference decode: control from a per-opcode table, immediates by plain integer arithmetic.
    function automatic dec_t mdec(input logic [31:0] ins, input logic [63:0] pc, input bit trap);
        dec_t       d;
        longint     v;
        bit         legal;
        logic [5:0] c;
        d = '0; v = 0; legal = 1'b1; c = '0;
        d.pc = pc; d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
        d.funct3 = ins[14:12]; d.f7b5 = ins[30];
        if (ins[1:0] != 2'b11) legal = 1'b0;
        else case (ins[6:0])
            7'h33: begin c = 6'b100000; d.aluop = 2'd2; d.immsrc = 3'd7; d.rs1_used = 1; d.rs2_used = 1; end
            7'h13: begin c = 6'b110000; d.aluop = 2'd2; d.immsrc = 3'd0; d.rs1_used = 1; end
            7'h03: begin c = 6'b111000; d.wb_sel = 2'd1; d.immsrc = 3'd0; d.rs1_used = 1; end
            7'h23: begin c = 6'b010100; d.immsrc = 3'd1; d.rs1_used = 1; d.rs2_used = 1; end
            7'h63: begin c = 6'b000010; d.aluop = 2'd1; d.immsrc = 3'd2; d.rs1_used = 1; d.rs2_used = 1; end
            7'h6F: begin c = 6'b110001; d.wb_sel = 2'd2; d.immsrc = 3'd4; d.jal = 1; end
            7'h67: begin c = 6'b110001; d.wb_sel = 2'd2; d.immsrc = 3'd0; d.jalr = 1; d.rs1_used = 1; end
            7'h37: begin c = 6'b110000; d.aluop = 2'd3; d.immsrc = 3'd3; end
            7'h17: begin c = 6'b110000; d.immsrc = 3'd3; end
            default: legal = 1'b0;
        endcase
        {d.regwrite, d.alusrc, d.memread, d.memwrite, d.branch, d.jump} = c;
        if (legal) case (d.immsrc)
            3'd0: begin v = longint'(ins[31:20]); if (v >= 2048) v -= 4096; end
            3'd1: begin v = longint'({ins[31:25], ins[11:7]}); if (v >= 2048) v -= 4096; end
            3'd2: begin
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                  + longint'(ins[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            3'd3: begin
                v = longint'(ins[31:12]) * 4096;
                if (v >= (longint'(1) << 31)) v -= (longint'(1) << 32);
            end
            3'd4: begin
                v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                  + longint'(ins[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            default: v = 0;
        endcase
        d.imm = 64'(v);
        d.illegal = !legal && trap;
        return d;
    endfunction

    function automatic bit m_haz(input int k);
        dec_t f;
        f = ment[k][0];
        return mcnt[k] > 0 && ex_load_valid && ex_load_rd != 5'd0 &&
               ((f.rs1_used && f.rs1 == ex_load_rd) || (f.rs2_used && f.rs2 == ex_load_rd));
    endfunction

    function automatic bit m_ov(input int k);
        return mcnt[k] > 0 && !m_haz(k);
    endfunction

    // Instance 0 holds up to two entries; instance 1 holds one and refills in the draining cycle.
    function automatic bit m_irdy(input int k);
        if (k == 0) return mcnt[k] < 2;
        return mcnt[k] == 0 || (m_ov(k) && out_ready);
    endfunction

    task automatic model_step();
        bit dr [2];
        bit ac [2];
        for (int k = 0; k < 2; k++) begin
            dr[k] = m_ov(k) && out_ready;
            ac[k] = in_valid && m_irdy(k) && !flush;
        end
        for (int k = 0; k < 2; k++) begin
            if (rst || flush) mcnt[k] = 0;
            else begin
                if (dr[k]) begin ment[k][0] = ment[k][1]; mcnt[k]--; end
                if (ac[k]) begin ment[k][mcnt[k]] = mdec(in_instr, in_pc, k == 0); mcnt[k]++; end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [63:0] pc);
        in_valid = 1'b1; in_instr = ins; in_pc = pc;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int kind;
        w = $urandom;
        kind = $urandom_range(0, 10);
        if (kind <= 8) w[6:0] = ops[kind];
        w[11:7] = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        if (kind == 10) w[1:0] = 2'($urandom_range(0, 2));
        return w;
    endfunction

    always @(negedge clk) begin
        if (started && !rst) begin
            for (int k = 0; k < 2; k++) begin
                chk_b($sformatf("out_valid[%0d]", k), out_valid_w[k], m_ov(k));
                chk_b($sformatf("in_ready[%0d]", k), in_ready_w[k], m_irdy(k));
                if (mcnt[k] > 0)
                    chk_v($sformatf("payload[%0d]", k), 192'(act[k]), 192'(ment[k][0]));
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 0; in_instr = '0; in_pc = '0; flush = 0;
        ex_load_valid = 0; ex_load_rd = '0; out_ready = 0;
        mcnt[0] = 0; mcnt[1] = 0;

        chk_v("model addi imm", 192'(mdec(I_ADDI, 0, 1).imm), 192'(64'h7F));
        chk_v("model lw wb_sel", 192'(mdec(I_LW, 0, 1).wb_sel), 192'(2'd1));
        chk_v("model beq imm", 192'(mdec(I_BEQ, 0, 1).imm), 192'(64'd16));
        chk_v("model jal imm", 192'(mdec(I_JAL, 0, 1).imm), 192'(64'd32));
        chk_v("model lui imm", 192'(mdec(I_LUI, 0, 1).imm), 192'(64'h12345000));
        chk_v("model sw imm", 192'(mdec(I_SW, 0, 1).imm), 192'(64'hFFFF_FFFF_FFFF_FFFC));
        chk_b("model illegal", mdec(I_BAD, 0, 1).illegal, 1'b1);

        #2;
        for (int k = 0; k < 2; k++) begin
            chk_b("reset out_valid", out_valid_w[k], 1'b0);
            chk_b("reset in_ready", in_ready_w[k], 1'b1);
            chk_v("reset payload", 192'(act[k]), 192'(0));
        end
        step(); step();
        rst = 1'b0; started = 1;
        step();

        // back-to-back with out_ready high
        out_ready = 1;
        offer(I_ADDI, 64'h100); step();
        offer(I_LW, 64'h104);
        for (int k = 0; k < 2; k++) begin
            chk_b("addi out_valid", out_valid_w[k], 1'b1);
            chk_v("addi imm", 192'(o_imm[k]), 192'(64'h7F));
            chk_v("addi aluop", 192'(o_aluop[k]), 192'(2'b10));
            chk_v("addi wb_sel", 192'(o_wb[k]), 192'(2'd0));
        end
        step(); in_valid = 0;
        for (int k = 0; k < 2; k++) begin
            chk_b("lw memread", o_mr[k], 1'b1);
            chk_v("lw wb_sel", 192'(o_wb[k]), 192'(2'd1));
            chk_v("lw imm", 192'(o_imm[k]), 192'(64'd24));
        end
        step(); step();

        // backpressure through the skid
        out_ready = 0;
        offer(I_BEQ, 64'h200); step();
        chk_b("bp in_ready after 1st", in_ready_w[0], 1'b1);
        offer(I_JAL, 64'h204); step();
        chk_b("bp in_ready after 2nd", in_ready_w[0], 1'b0);
        offer(I_LUI, 64'h208); step();
        chk_v("bp beq imm", 192'(o_imm[0]), 192'(64'd16));
        chk_v("bp beq aluop", 192'(o_aluop[0]), 192'(2'b01));
        out_ready = 1; step();
        chk_v("bp jal imm", 192'(o_imm[0]), 192'(64'd32));
        chk_v("bp jal wb_sel", 192'(o_wb[0]), 192'(2'd2));
        chk_b("bp jal JAL", o_jal[0], 1'b1);
        step(); in_valid = 0;
        chk_v("bp lui imm", 192'(o_imm[0]), 192'(64'h12345000));
        chk_v("bp lui pc", 192'(o_pc[0]), 192'(64'h208));
        step(); step();

        // load-use hazard on a held add x5,x1,x2
        out_ready = 0;
        offer(I_ADD, 64'h300); step(); in_valid = 0;
        ex_load_valid = 1; ex_load_rd = 5'd2; #1;
        chk_b("lu rd=2 out_valid", out_valid_w[0], 1'b0);
        ex_load_rd = 5'd0; #1;
        chk_b("lu rd=0 out_valid", out_valid_w[0], 1'b1);
        ex_load_rd = 5'd5; #1;
        chk_b("lu rd=5 out_valid", out_valid_w[0], 1'b1);
        ex_load_rd = 5'd1; out_ready = 1; step();
        chk_b("lu held out_valid", out_valid_w[0], 1'b0);
        chk_v("lu held pc", 192'(o_pc[0]), 192'(64'h300));
        ex_load_valid = 0; step(); step();

        // flush with both entries full and a new offer
        out_ready = 0;
        offer(I_ADDI, 64'h400); step();
        offer(I_LW, 64'h404); step();
        offer(I_SW, 64'h408); flush = 1; step();
        flush = 0; in_valid = 0;
        for (int k = 0; k < 2; k++) begin
            chk_b("flush out_valid", out_valid_w[k], 1'b0);
            chk_b("flush in_ready", in_ready_w[k], 1'b1);
        end
        out_ready = 1; step(); step();
        chk_b("flush nothing emitted", out_valid_w[0], 1'b0);

        // illegal opcode and negative store offset
        offer(I_BAD, 64'h500); step();
        offer(I_SW, 64'h504);
        chk_b("ill out_illegal[0]", o_ill[0], 1'b1);
        chk_b("ill out_illegal[1]", o_ill[1], 1'b0);
        chk_v("ill ctl", 192'({o_rw[0], o_mw[0], o_br[0], o_jp[0]}), 192'(4'b0));
        step(); in_valid = 0;
        chk_v("sw imm", 192'(o_imm[0]), 192'(64'hFFFF_FFFF_FFFF_FFFC));
        chk_b("sw memwrite", o_mw[0], 1'b1);
        step(); step();

        for (int c = 0; c < 2500; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = rand_instr();
            in_pc = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 39) == 0);
            ex_load_valid = ($urandom_range(0, 2) == 0);
            ex_load_rd = 5'($urandom_range(0, 7));
            step();
        end

        // asynchronous reset while an instruction is held
        flush = 0; ex_load_valid = 0; out_ready = 0;
        offer(I_LUI, 64'h600); step(); in_valid = 0;
        chk_b("pre-reset out_valid", out_valid_w[0], 1'b1);
        rst = 1; mcnt[0] = 0; mcnt[1] = 0; #1;
        for (int k = 0; k < 2; k++) begin
            chk_b("midrst out_valid", out_valid_w[k], 1'b0);
            chk_v("midrst out_imm", 192'(o_imm[k]), 192'(0));
            chk_b("midrst in_ready", in_ready_w[k], 1'b1);
        end
        step(); rst = 0;
        for (int c = 0; c < 200; c++) begin
            in_valid = ($urandom_range(0, 1) != 0);
            in_instr = rand_instr();
            in_pc = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            ex_load_valid = ($urandom_range(0, 3) == 0);
            ex_load_rd = 5'($urandom_range(0, 7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
